// File: rtl/expr_pkg.sv
// Field layout of the packed 90-bit expression result bus y = {y0,...,y17}.
package expr_pkg;

    localparam int BUS_W      = 90;
    localparam int NUM_FIELDS = 18;
    localparam int OUT_W      = 8;
    localparam int SIG_W      = 16;

    typedef logic [4:0] field_idx_t;

    localparam field_idx_t LAST_IDX = field_idx_t'(NUM_FIELDS - 1);

    // Widths cycle 4,5,6 so every group of three fields spans 15 bits.
    localparam int FIELD_W [NUM_FIELDS] = '{
        4, 5, 6,  4, 5, 6,  4, 5, 6,
        4, 5, 6,  4, 5, 6,  4, 5, 6
    };

    // MSB of each field; y0 sits at the top of the bus.
    localparam int FIELD_MSB [NUM_FIELDS] = '{
        89, 85, 80,  74, 70, 65,
        59, 55, 50,  44, 40, 35,
        29, 25, 20,  14, 10,  5
    };

    // Second group of three in every six-field block is signed.
    localparam bit FIELD_SIGNED [NUM_FIELDS] = '{
        1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1
    };

endpackage

// File: rtl/expr_field_extract.sv
// Combinational field selector: picks field idx_i out of the packed word and
// extends it to OUT_W bits according to the field's signedness.
module expr_field_extract
    import expr_pkg::*;
(
    input  logic [BUS_W-1:0] shadow_i,
    input  field_idx_t       idx_i,
    output logic [OUT_W-1:0] field_o
);

    logic [OUT_W-1:0] field_ext [NUM_FIELDS];

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
        localparam int W   = FIELD_W[gi];
        localparam int MSB = FIELD_MSB[gi];
        logic [W-1:0] raw;
        assign raw = shadow_i[MSB -: W];
        if (FIELD_SIGNED[gi]) begin : g_sext
            assign field_ext[gi] = {{(OUT_W - W){raw[W-1]}}, raw};
        end else begin : g_zext
            assign field_ext[gi] = {{(OUT_W - W){1'b0}}, raw};
        end
    end

    // Index mux; out-of-range indices yield zero.
    always_comb begin
        field_o = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (idx_i == field_idx_t'(i)) begin
                field_o = field_ext[i];
            end
        end
    end

endmodule

// File: rtl/expr_result_unpacker.sv
// Receive end of the packed expression result bus: accepts one word per
// handshake, streams its 18 extended fields out one per beat and produces a
// rotate-xor signature per finished word.
module expr_result_unpacker
    import expr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_field,
    output field_idx_t       out_idx,
    output logic             out_last,
    output logic             sig_valid,
    output logic [SIG_W-1:0] sig
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_q, state_d;
    field_idx_t       idx_q, idx_d;
    logic [BUS_W-1:0] shadow_q, shadow_d;
    logic [SIG_W-1:0] sig_acc_q, sig_acc_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             sig_valid_q, sig_valid_d;

    logic [OUT_W-1:0] field_raw;
    logic [SIG_W-1:0] sig_step;
    logic             emitting;
    logic             out_xfer;
    logic             last_xfer;
    logic             in_xfer;

    expr_field_extract u_extract (
        .shadow_i (shadow_q),
        .idx_i    (idx_q),
        .field_o  (field_raw)
    );

    // Handshakes, output drive and next-state computation.
    always_comb begin
        emitting  = (state_q == EMIT);
        out_xfer  = emitting && out_ready;
        last_xfer = out_xfer && (idx_q == LAST_IDX);
        in_ready  = !emitting || last_xfer;
        in_xfer   = in_valid && in_ready;

        // Outputs are forced to zero outside EMIT so idle/reset values are all 0.
        out_valid = emitting;
        out_field = emitting ? field_raw : '0;
        out_idx   = emitting ? idx_q : '0;
        out_last  = emitting && (idx_q == LAST_IDX);
        sig_valid = sig_valid_q;
        sig       = sig_q;

        sig_step  = {sig_acc_q[SIG_W-2:0], sig_acc_q[SIG_W-1]}
                    ^ {{(SIG_W - OUT_W){1'b0}}, field_raw};

        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        sig_acc_d   = sig_acc_q;
        sig_d       = sig_q;
        sig_valid_d = 1'b0;

        if (out_xfer) begin
            sig_acc_d = sig_step;
            if (last_xfer) begin
                state_d     = IDLE;
                sig_d       = sig_step;
                sig_valid_d = 1'b1;
            end else begin
                idx_d = field_idx_t'(idx_q + 5'd1);
            end
        end

        // A new word (possibly in the same cycle as the last beat) restarts the stream.
        if (in_xfer) begin
            state_d   = EMIT;
            idx_d     = '0;
            shadow_d  = in_data;
            sig_acc_d = '0;
        end
    end

    // State, counter, shadow word and signature registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            sig_acc_q   <= '0;
            sig_q       <= '0;
            sig_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            sig_acc_q   <= sig_acc_d;
            sig_q       <= sig_d;
            sig_valid_q <= sig_valid_d;
        end
    end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Directed bench for expr_result_unpacker: table of packed words with
// hand-computed field values, plus stall, back-to-back and reset sequences.
module tb_expr_result_unpacker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_field;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        sig_valid;
    logic [15:0] sig;

    expr_result_unpacker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .sig_valid (sig_valid),
        .sig       (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [89:0]       data;
        logic [17:0][7:0]  f;
    } vec_t;

    vec_t vecs [6];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sig_model(input logic [17:0][7:0] f);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int j = 0; j < 18; j++) begin
            acc = {acc[14:0], acc[15]} ^ {8'h00, f[j]};
        end
        return acc;
    endfunction

    function automatic logic [89:0] bit_at(input int pos);
        logic [89:0] one;
        one = 90'd1;
        return one << pos;
    endfunction

    // One word: handshake in, collect 18 beats (optionally stalling every other cycle), check signature.
    task automatic send_word(input int vi, input bit toggle);
        int          k;
        int          cyc;
        logic [95:0] junk;
        logic [15:0] exp_sig;
        exp_sig  = sig_model(vecs[vi].f);
        in_valid = 1'b1;
        in_data  = vecs[vi].data;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        check("out_valid_idle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        junk     = {$urandom, $urandom, $urandom};
        in_data  = junk[89:0];
        k   = 0;
        cyc = 0;
        while (k < 18 && cyc < 100) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            @(negedge clk);
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_idx", 32'(out_idx), 32'(k));
            check("out_field", 32'(out_field), 32'(vecs[vi].f[k]));
            check("out_last", 32'(out_last), 32'(k == 17));
            check("sig_valid_quiet", 32'(sig_valid), 32'd0);
            if (out_ready) k++;
            cyc++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        check("beats", 32'(k), 32'd18);
        if (toggle) check("toggle_cycles", 32'(cyc), 32'd36);
        @(negedge clk);
        check("sig_valid_pulse", 32'(sig_valid), 32'd1);
        check("sig_value", 32'(sig), 32'(exp_sig));
        check("out_valid_after", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sig_valid_one_cycle", 32'(sig_valid), 32'd0);
        check("sig_hold", 32'(sig), 32'(exp_sig));
        @(posedge clk);
        #1;
    endtask

    // Three words offered back to back with in_valid held high: 54 beats, no bubbles.
    task automatic back_to_back();
        int          rows [3];
        int          beat;
        int          cur_in;
        int          sigs_seen;
        logic        acc;
        logic [95:0] junk;
        rows[0] = 0; rows[1] = 4; rows[2] = 5;
        beat = 0; cur_in = 0; sigs_seen = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vecs[rows[0]].data;
        for (int c = 0; c < 120 && (beat < 54 || sigs_seen < 3); c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (sig_valid) begin
                if (sigs_seen < 3)
                    check("b2b_sig", 32'(sig), 32'(sig_model(vecs[rows[sigs_seen]].f)));
                sigs_seen++;
            end
            if (beat > 0 && beat < 54)
                check("b2b_no_bubble", 32'(out_valid), 32'd1);
            if (out_valid && beat < 54) begin
                check("b2b_idx", 32'(out_idx), 32'(beat % 18));
                check("b2b_field", 32'(out_field), 32'(vecs[rows[beat / 18]].f[beat % 18]));
                beat++;
            end
            @(posedge clk);
            #1;
            if (acc) cur_in++;
            in_valid = (cur_in < 3);
            if (cur_in < 3) begin
                in_data = vecs[rows[cur_in]].data;
            end else begin
                junk    = {$urandom, $urandom, $urandom};
                in_data = junk[89:0];
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_beats", 32'(beat), 32'd54);
        check("b2b_sig_count", 32'(sigs_seen), 32'd3);
        @(posedge clk);
        #1;
    endtask

    // Reset asserted while field 7 is on the output.
    task automatic reset_mid_word();
        bit found;
        bit seen_sig;
        found = 1'b0;
        in_valid  = 1'b1;
        in_data   = vecs[0].data;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (out_valid && out_idx == 5'd7) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("rst_reached_idx7", 32'(found), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_field", 32'(out_field), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sig", 32'(sig), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_sig = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (sig_valid || out_valid) seen_sig = 1'b1;
            @(posedge clk);
            #1;
        end
        check("rst_dropped_word", 32'(seen_sig), 32'd0);
    endtask

    initial begin
        logic [7:0] pat [6];
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        pat[0] = 8'h0F; pat[1] = 8'h1F; pat[2] = 8'h3F;
        pat[3] = 8'hFF; pat[4] = 8'hFF; pat[5] = 8'hFF;
        for (int v = 0; v < 6; v++) vecs[v].f = '0;
        // all ones
        vecs[0].data = '1;
        for (int j = 0; j < 18; j++) vecs[0].f[j] = pat[j % 6];
        // all zeros
        vecs[1].data = '0;
        // only bit 89: top bit of unsigned y0
        vecs[2].data = bit_at(89);
        vecs[2].f[0] = 8'h08;
        // only bit 74: sign bit of y3
        vecs[3].data = bit_at(74);
        vecs[3].f[3] = 8'hF8;
        // bit 84 inside y1, bit 5 = sign bit of y17
        vecs[4].data = bit_at(84) | bit_at(5);
        vecs[4].f[1]  = 8'h08;
        vecs[4].f[17] = 8'hE0;
        // y5 sign bit, y8 top bit, y9 = +7, y17 = +1
        vecs[5].data = bit_at(65) | bit_at(50) | bit_at(43) | bit_at(42) | bit_at(41) | bit_at(0);
        vecs[5].f[5]  = 8'hE0;
        vecs[5].f[8]  = 8'h20;
        vecs[5].f[9]  = 8'h07;
        vecs[5].f[17] = 8'h01;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_sig_valid", 32'(sig_valid), 32'd0);
        check("reset_sig", 32'(sig), 32'd0);
        check("reset_out_field", 32'(out_field), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            send_word(v, 1'b0);
            $display("word %0d: data=%023h sig=%04h", v, vecs[v].data, sig);
        end
        send_word(0, 1'b1);
        $display("stalled word: sig=%04h", sig);
        back_to_back();
        $display("back-to-back: three words streamed");
        reset_mid_word();
        $display("reset mid-word applied");
        send_word(5, 1'b0);
        $display("post-reset word: sig=%04h", sig);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
